// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state type, constants and region decode helper for mem_bus_decoder
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, RAM, SLV, RESP} state_t;
  localparam logic [31:0] ERR_DATA_DEF = 32'hBADB_AD00;
  localparam int ERR_CNT_W = 8;
  function automatic logic region_match(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction
endpackage

// File: rtl/mem_bus_decoder_if.sv
// mem_bus_decoder_if: core-side, RAM-side and slave-side signals of mem_bus_decoder
interface mem_bus_decoder_if import mem_bus_pkg::*; #(parameter int NUM_SLAVES = 4);
  logic mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  logic ram_en;
  logic [3:0] ram_wen;
  logic [31:0] ram_addr, ram_rdata;
  logic [NUM_SLAVES-1:0] slv_valid, slv_ready;
  logic [32*NUM_SLAVES-1:0] slv_rdata;
  logic [31:0] slv_addr, slv_wdata;
  logic [3:0] slv_wstrb;
  logic err_irq, err_instr;
  logic [31:0] err_addr;
  logic [ERR_CNT_W-1:0] err_count;
  modport slave (
    input mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, ram_rdata, slv_ready, slv_rdata,
    output mem_ready, mem_rdata, ram_en, ram_wen, ram_addr, slv_valid, slv_addr, slv_wdata, slv_wstrb,
    output err_irq, err_addr, err_instr, err_count
  );
  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, ram_rdata, slv_ready, slv_rdata,
    input mem_ready, mem_rdata, ram_en, ram_wen, ram_addr, slv_valid, slv_addr, slv_wdata, slv_wstrb,
    input err_irq, err_addr, err_instr, err_count
  );
endinterface

// File: rtl/mem_bus_timeout.sv
// mem_bus_timeout: 16-bit slave watchdog counter; o_hit marks the edge on which it reaches TIMEOUT
module mem_bus_timeout #(parameter int TIMEOUT = 255) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);
  logic [15:0] r_cnt;
  always_ff @(posedge clk)
    if (!resetn || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 16'd1;
  assign o_hit = r_cnt == 16'(TIMEOUT - 1);
endmodule

// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder: registered picorv32 bus decoder for one RAM plus NUM_SLAVES mapped slaves,
// with RAM wait states, a slave watchdog and bus-error reporting.
module mem_bus_decoder import mem_bus_pkg::*; #(
  parameter int NUM_SLAVES = 4,
  parameter int RAM_WORDS = 256,
  parameter int RAM_WAIT = 0,
  parameter logic [32*NUM_SLAVES-1:0] SLV_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0] SLV_MASK = {NUM_SLAVES{32'hFFFF_FFFF}},
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input logic clk,
  input logic resetn,
  mem_bus_decoder_if.slave bus
);
  state_t r_state, w_nxt;
  logic [31:0] r_addr, r_wdata, r_rdata, r_err_addr, w_srd;
  logic [3:0] r_wstrb, r_ram_wen, r_wait;
  logic [NUM_SLAVES-1:0] r_sel, w_hit, w_sel;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic r_instr, r_ready, r_ram_en, r_irq, r_err_instr, r_err_pend;
  logic w_ram, w_rdy, w_to, w_acc, w_done, w_err;
  always_comb begin
    w_hit = '0;
    w_srd = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      w_hit[k] = region_match(bus.mem_addr, SLV_BASE[32*k +: 32], SLV_MASK[32*k +: 32]);
      w_srd = w_srd | (bus.slv_rdata[32*k +: 32] & {32{r_sel[k]}});
    end
  end
  // isolate the lowest set bit so overlapping regions resolve to the lowest index
  assign w_sel = w_hit & (~w_hit + NUM_SLAVES'(1));
  assign w_ram = bus.mem_addr < 32'(4 * RAM_WORDS);
  assign w_rdy = |(r_sel & bus.slv_ready);
  mem_bus_timeout #(.TIMEOUT(TIMEOUT)) u_to (
    .clk(clk), .resetn(resetn), .i_clr(r_state != SLV), .i_en(r_state == SLV), .o_hit(w_to)
  );
  always_comb begin
    w_nxt = r_state;
    w_acc = 1'b0;
    w_done = 1'b0;
    w_err = 1'b0;
    case (r_state)
      IDLE: if (bus.mem_valid) begin
        w_acc = 1'b1;
        w_nxt = w_ram ? RAM : (|w_sel ? SLV : RESP);
      end
      RAM: if (r_wait == 4'(RAM_WAIT + 1)) begin
        w_done = 1'b1;
        w_nxt = RESP;
      end
      SLV: begin
        w_done = w_rdy;
        w_err = !w_rdy && w_to;
        w_nxt = (w_rdy || w_to) ? RESP : SLV;
      end
      // an unmapped access enters RESP with the error pending and completes one cycle later
      RESP: begin
        w_err = r_err_pend;
        w_nxt = r_err_pend ? RESP : IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_nxt;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_instr <= 1'b0;
      r_sel <= '0;
      r_wait <= '0;
      r_ram_en <= 1'b0;
      r_ram_wen <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_irq <= 1'b0;
      r_err_pend <= 1'b0;
      r_err_addr <= '0;
      r_err_instr <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_ram_en <= w_acc && w_ram;
      r_ram_wen <= (w_acc && w_ram) ? bus.mem_wstrb : 4'd0;
      r_ready <= w_done || w_err;
      r_irq <= w_err;
      r_err_pend <= w_acc && !w_ram && !(|w_sel);
      r_wait <= (r_state == RAM) ? r_wait + 4'd1 : 4'd0;
      if (w_acc) begin
        r_addr <= bus.mem_addr;
        r_wdata <= bus.mem_wdata;
        r_wstrb <= bus.mem_wstrb;
        r_instr <= bus.mem_instr;
        r_sel <= w_ram ? '0 : w_sel;
      end
      if (w_done || w_err) r_sel <= '0;
      if (w_done) r_rdata <= |r_wstrb ? 32'd0 : ((r_state == RAM) ? bus.ram_rdata : w_srd);
      if (w_err) begin
        r_rdata <= ERR_DATA;
        r_err_addr <= r_addr;
        r_err_instr <= r_instr;
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(~&r_err_cnt);
      end
    end
  end
  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;
  assign bus.ram_en = r_ram_en;
  assign bus.ram_wen = r_ram_wen;
  assign bus.ram_addr = r_addr;
  assign bus.slv_valid = r_sel;
  assign bus.slv_addr = r_addr;
  assign bus.slv_wdata = r_wdata;
  assign bus.slv_wstrb = r_wstrb;
  assign bus.err_irq = r_irq;
  assign bus.err_addr = r_err_addr;
  assign bus.err_instr = r_err_instr;
  assign bus.err_count = r_err_cnt;
endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb_mem_bus_decoder: directed self-checking bench for mem_bus_decoder (2 slaves, RAM_WAIT=1, TIMEOUT=16)
module tb_mem_bus_decoder;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;
  mem_bus_decoder_if #(.NUM_SLAVES(2)) bus ();
  mem_bus_decoder #(
    .NUM_SLAVES(2), .RAM_WORDS(256), .RAM_WAIT(1),
    .SLV_BASE({32'h0300_0000, 32'h0200_0000}),
    .SLV_MASK({32'hFF00_0000, 32'hFFFF_FF00}),
    .TIMEOUT(16)
  ) dut (.clk(clk), .resetn(resetn), .bus(bus));
  int checks = 0, failures = 0;
  int n_ram_en = 0, n_ready = 0, n_irq = 0, n_slv = 0;
  logic [3:0] last_wen;
  logic [31:0] last_raddr, ram_q;
  logic [181:0] w_outs;
  assign w_outs = {bus.mem_ready, bus.mem_rdata, bus.ram_en, bus.ram_wen, bus.ram_addr, bus.slv_valid,
                   bus.slv_addr, bus.slv_wdata, bus.slv_wstrb, bus.err_irq, bus.err_addr, bus.err_instr, bus.err_count};
  always @(posedge clk) if (bus.ram_en) bus.ram_rdata <= ram_q;
  always @(negedge clk) begin
    if (bus.ram_en) begin
      n_ram_en++;
      last_wen = bus.ram_wen;
      last_raddr = bus.ram_addr;
    end
    if (bus.mem_ready) n_ready++;
    if (bus.err_irq) n_irq++;
    if (bus.slv_valid != 2'b00) n_slv++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic ins);
    bus.mem_valid = 1'b1;
    bus.mem_addr = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    bus.mem_instr = ins;
  endtask
  task automatic run(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic ins, output int lat);
    drive(a, d, s, ins);
    tick();
    lat = 1;
    while (bus.mem_ready !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    bus.mem_valid = 1'b0;
    tick();
  endtask
  task automatic test_reset;
    resetn = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    bus.slv_ready = '0;
    bus.slv_rdata = '0;
    ram_q = '0;
    repeat (3) tick();
    checks++;
    if (w_outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", w_outs); end
    resetn = 1'b1;
    tick();
  endtask
  task automatic test_ram_read;
    int lat, r0, e0, s0;
    ram_q = 32'h1234_5678;
    r0 = n_ram_en; e0 = n_ready; s0 = n_slv;
    run(32'h0000_0010, 32'h0, 4'b0000, 1'b0, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL ram_read_latency got=%0d exp=4", lat); end
    checks++;
    if (bus.mem_rdata !== 32'h1234_5678) begin failures++; $display("FAIL ram_read_data got=%h exp=12345678", bus.mem_rdata); end
    checks++;
    if (n_ram_en - r0 !== 1 || last_wen !== 4'b0000 || last_raddr !== 32'h10)
      begin failures++; $display("FAIL ram_en_pulse got=%0d/%b/%h exp=1/0000/00000010", n_ram_en - r0, last_wen, last_raddr); end
    checks++;
    if (n_ready - e0 !== 1 || n_slv - s0 !== 0)
      begin failures++; $display("FAIL ram_ready_pulse got=%0d/%0d exp=1/0", n_ready - e0, n_slv - s0); end
  endtask
  task automatic test_slv_write;
    int bad = 0, r0;
    r0 = n_ram_en;
    bus.slv_rdata = {32'h5555_AAAA, 32'h1111_2222};
    drive(32'h0300_0004, 32'hCAFE_F00D, 4'b0011, 1'b0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (bus.slv_valid !== 2'b10 || bus.slv_addr !== 32'h0300_0004 || bus.slv_wdata !== 32'hCAFE_F00D ||
          bus.slv_wstrb !== 4'b0011 || bus.mem_ready !== 1'b0) bad++;
      bus.slv_ready = (c == 3) ? 2'b10 : 2'b01;
      tick();
    end
    bus.slv_ready = 2'b00;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL slv_write_hold got=%0d bad cycles exp=0", bad); end
    checks++;
    if (bus.mem_ready !== 1'b1 || bus.slv_valid !== 2'b00)
      begin failures++; $display("FAIL slv_write_ready got=%b/%b exp=1/00", bus.mem_ready, bus.slv_valid); end
    checks++;
    if (bus.mem_rdata !== 32'h0 || n_ram_en !== r0)
      begin failures++; $display("FAIL slv_write_rdata got=%h ram_en=%0d exp=00000000/0", bus.mem_rdata, n_ram_en - r0); end
    bus.mem_valid = 1'b0;
    tick();
    checks++;
    if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL slv_write_pulse got=%b exp=0", bus.mem_ready); end
  endtask
  task automatic test_ram_boundary;
    int lat;
    ram_q = 32'hA5A5_0001;
    run(32'h0000_03FC, 32'h0, 4'b0000, 1'b0, lat);
    checks++;
    if (lat !== 4 || bus.mem_rdata !== 32'hA5A5_0001 || last_raddr !== 32'h3FC)
      begin failures++; $display("FAIL ram_last_word got=%0d/%h exp=4/a5a50001", lat, bus.mem_rdata); end
    run(32'h0000_0020, 32'hDEAD_BEEF, 4'b1111, 1'b0, lat);
    checks++;
    if (lat !== 4 || bus.mem_rdata !== 32'h0 || last_wen !== 4'b1111)
      begin failures++; $display("FAIL ram_write got=%0d/%h/%b exp=4/00000000/1111", lat, bus.mem_rdata, last_wen); end
  endtask
  task automatic test_slv_timeout;
    int c = 1, nv = 0, i0;
    i0 = n_irq;
    drive(32'h0200_0000, 32'h0, 4'b0000, 1'b1);
    tick();
    while (bus.mem_ready !== 1'b1 && c < 64) begin
      if (bus.slv_valid === 2'b01) nv++;
      tick();
      c++;
    end
    checks++;
    if (c !== 17 || nv !== 16) begin failures++; $display("FAIL timeout_latency got=%0d/%0d exp=17/16", c, nv); end
    checks++;
    if (bus.mem_rdata !== 32'hBADB_AD00 || bus.err_irq !== 1'b1 || bus.slv_valid !== 2'b00)
      begin failures++; $display("FAIL timeout_resp got=%h/%b/%b exp=badbad00/1/00", bus.mem_rdata, bus.err_irq, bus.slv_valid); end
    checks++;
    if (bus.err_addr !== 32'h0200_0000 || bus.err_instr !== 1'b1 || bus.err_count !== 8'd1)
      begin failures++; $display("FAIL timeout_err_regs got=%h/%b/%0d exp=02000000/1/1", bus.err_addr, bus.err_instr, bus.err_count); end
    bus.mem_valid = 1'b0;
    tick();
    checks++;
    if (bus.err_irq !== 1'b0 || bus.mem_ready !== 1'b0 || n_irq - i0 !== 1)
      begin failures++; $display("FAIL timeout_irq_pulse got=%b/%b/%0d exp=0/0/1", bus.err_irq, bus.mem_ready, n_irq - i0); end
  endtask
  task automatic test_unmapped;
    int lat, bad = 0, i0, r0;
    run(32'h0100_0000, 32'h0, 4'b0000, 1'b0, lat);
    checks++;
    if (lat !== 2 || bus.mem_rdata !== 32'hBADB_AD00)
      begin failures++; $display("FAIL unmapped_resp got=%0d/%h exp=2/badbad00", lat, bus.mem_rdata); end
    checks++;
    if (bus.err_count !== 8'd2 || bus.err_addr !== 32'h0100_0000 || bus.err_instr !== 1'b0)
      begin failures++; $display("FAIL unmapped_err_regs got=%0d/%h/%b exp=2/01000000/0", bus.err_count, bus.err_addr, bus.err_instr); end
    r0 = n_ram_en;
    run(32'h0000_0400, 32'h0, 4'b0000, 1'b0, lat);
    checks++;
    if (lat !== 2 || n_ram_en !== r0 || bus.err_count !== 8'd3 || bus.err_addr !== 32'h400)
      begin failures++; $display("FAIL ram_end_unmapped got=%0d/%0d/%0d/%h exp=2/0/3/00000400", lat, n_ram_en - r0, bus.err_count, bus.err_addr); end
    i0 = n_irq;
    for (int i = 0; i < 256; i++) begin
      run(32'h0100_0000 + 32'(i * 16), 32'h0, 4'b0000, 1'b0, lat);
      if (lat !== 2) bad++;
    end
    checks++;
    if (bad !== 0 || bus.err_count !== 8'd255 || n_irq - i0 !== 256)
      begin failures++; $display("FAIL err_count_saturate got=%0d/%0d/%0d exp=0/255/256", bad, bus.err_count, n_irq - i0); end
  endtask
  task automatic test_ready_vs_timeout;
    int c = 1, i0;
    i0 = n_irq;
    bus.slv_rdata = {32'h0, 32'h7777_1111};
    drive(32'h0200_0010, 32'h0, 4'b0000, 1'b0);
    tick();
    while (bus.mem_ready !== 1'b1 && c < 64) begin
      bus.slv_ready = (c == 16) ? 2'b01 : 2'b00;
      tick();
      c++;
    end
    bus.slv_ready = 2'b00;
    checks++;
    if (c !== 17 || bus.mem_rdata !== 32'h7777_1111)
      begin failures++; $display("FAIL ready_at_timeout got=%0d/%h exp=17/77771111", c, bus.mem_rdata); end
    bus.mem_valid = 1'b0;
    tick();
    checks++;
    if (n_irq !== i0 || bus.err_count !== 8'd255)
      begin failures++; $display("FAIL ready_at_timeout_noerr got=%0d/%0d exp=0/255", n_irq - i0, bus.err_count); end
  endtask
  task automatic test_reset_mid_txn;
    int lat, e0;
    drive(32'h0200_0000, 32'h0, 4'b0000, 1'b0);
    tick();
    tick();
    resetn = 1'b0;
    e0 = n_ready;
    tick();
    checks++;
    if (w_outs !== '0) begin failures++; $display("FAIL reset_mid_outputs got=%h exp=0", w_outs); end
    bus.mem_valid = 1'b0;
    resetn = 1'b1;
    repeat (3) tick();
    checks++;
    if (n_ready !== e0 || bus.slv_valid !== 2'b00)
      begin failures++; $display("FAIL reset_mid_no_ready got=%0d/%b exp=0/00", n_ready - e0, bus.slv_valid); end
    ram_q = 32'h0F0F_1234;
    run(32'h0000_0044, 32'h0, 4'b0000, 1'b0, lat);
    checks++;
    if (lat !== 4 || bus.mem_rdata !== 32'h0F0F_1234)
      begin failures++; $display("FAIL reset_then_ram got=%0d/%h exp=4/0f0f1234", lat, bus.mem_rdata); end
  endtask
  initial begin
    test_reset();
    test_ram_read();
    test_slv_write();
    test_ram_boundary();
    test_slv_timeout();
    test_unmapped();
    test_ready_vs_timeout();
    test_reset_mid_txn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
